count_sched: RTL and testbench

- Time-shares one WIDTH-bit up-counter datapath among NUM_REQ requesters.
- Each requester asks for an interval of a given length. A round-robin arbiter grants the counter to one requester at a time.
- The counter runs from 0 for the requested number of cycles, then the block returns a one-cycle done pulse to the owner.
- Sits between per-channel timing clients and the shared counter. It replaces per-client counters.

---
 rtl/count_sched_pkg.sv | 30 +++
 rtl/count_sched_rr_arbiter.sv | 30 +++
 rtl/count_sched.sv | 141 ++++++++++++++
 tb/tb_count_sched.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_sched_pkg.sv
// Shared types and helpers for the time-shared interval counter.
package count_sched_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 4;

  // Widest requester vector the one-hot helper supports.
  localparam int MAX_REQ     = 8;

  // state  | meaning
  // IDLE   | counter free, arbitrating among pending requests
  // RUN    | counter owned by one requester, counting up from 0
  // DONE   | one-cycle completion pulse to the owner, pointer rotated
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Requester index wrapped into 0..n-1.
  function automatic int wrap_index(input int idx, input int n);
    return idx % n;
  endfunction

  // One-hot vector for a requester index.
  function automatic logic [MAX_REQ-1:0] onehot(input int idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/count_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer,
// wrapping around. The caller registers the result.
module rr_arbiter
  import count_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IW-1:0]      o_idx,
  output logic               o_valid
);

  // Scan upward from the pointer; the first hit wins.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!o_valid && i_req[wrap_index(int'(i_ptr) + k, NUM_REQ)]) begin
        o_valid = 1'b1;
        o_idx   = IW'(wrap_index(int'(i_ptr) + k, NUM_REQ));
        o_gnt[wrap_index(int'(i_ptr) + k, NUM_REQ)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/count_sched.sv
// Shares one up-counter among several timing clients. The owner's interval
// length is captured at grant time; a zero length means a full wrap.
module count_sched
  import count_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] len,
  input  logic                     abort,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic [WIDTH-1:0]         count,
  output logic [NUM_REQ-1:0]       done,
  output logic                     aborted
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               r_state;
  logic [IW-1:0]        r_ptr;
  logic [IW-1:0]        r_idx;
  logic [WIDTH-1:0]     r_len;
  logic [NUM_REQ-1:0]   r_grant;
  logic                 r_busy;
  logic [WIDTH-1:0]     r_count;
  logic [NUM_REQ-1:0]   r_done;
  logic                 r_aborted;

  state_t               w_state_nxt;
  logic [IW-1:0]        w_ptr_nxt;
  logic [IW-1:0]        w_idx_nxt;
  logic [WIDTH-1:0]     w_len_nxt;
  logic [NUM_REQ-1:0]   w_grant_nxt;
  logic                 w_busy_nxt;
  logic [WIDTH-1:0]     w_count_nxt;
  logic [NUM_REQ-1:0]   w_done_nxt;
  logic                 w_aborted_nxt;

  logic [NUM_REQ-1:0]   w_arb_gnt;
  logic [IW-1:0]        w_arb_idx;
  logic                 w_arb_valid;
  logic                 w_terminal;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_gnt   (w_arb_gnt),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  // L-1 wraps to all-ones for L=0, giving the full 2^WIDTH interval.
  assign w_terminal = (r_count == (r_len - WIDTH'(1)));

  // Next state and next registered outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_idx_nxt     = r_idx;
    w_len_nxt     = r_len;
    w_grant_nxt   = r_grant;
    w_busy_nxt    = r_busy;
    w_count_nxt   = r_count;
    w_done_nxt    = '0;
    w_aborted_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_arb_valid) begin
          w_state_nxt = S_RUN;
          w_grant_nxt = w_arb_gnt;
          w_busy_nxt  = 1'b1;
          w_count_nxt = '0;
          w_idx_nxt   = w_arb_idx;
          w_len_nxt   = len[int'(w_arb_idx)*WIDTH +: WIDTH];
        end
      end
      S_RUN: begin
        // Terminal count takes precedence over abort or a dropped request.
        if (w_terminal || abort || !req[r_idx]) begin
          w_state_nxt   = S_DONE;
          w_grant_nxt   = '0;
          w_busy_nxt    = 1'b0;
          w_count_nxt   = '0;
          w_done_nxt    = r_grant;
          w_aborted_nxt = !w_terminal;
          w_ptr_nxt     = IW'(wrap_index(int'(r_idx) + 1, NUM_REQ));
        end else begin
          w_count_nxt = r_count + WIDTH'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
        w_count_nxt = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_len     <= '0;
      r_grant   <= '0;
      r_busy    <= 1'b0;
      r_count   <= '0;
      r_done    <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_idx     <= w_idx_nxt;
      r_len     <= w_len_nxt;
      r_grant   <= w_grant_nxt;
      r_busy    <= w_busy_nxt;
      r_count   <= w_count_nxt;
      r_done    <= w_done_nxt;
      r_aborted <= w_aborted_nxt;
    end
  end

  assign grant   = r_grant;
  assign busy    = r_busy;
  assign count   = r_count;
  assign done    = r_done;
  assign aborted = r_aborted;

endmodule

// File: tb/tb_count_sched.sv
// Bench for count_sched: each scenario queues per-cycle stimulus alongside the
// expected registered outputs, then replays and compares cycle by cycle.
module tb_count_sched;

  localparam int N = 4;
  localparam int W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [N*W-1:0]   len;
  logic             abort;
  logic [N-1:0]     grant;
  logic             busy;
  logic [W-1:0]     count;
  logic [N-1:0]     done;
  logic             aborted;

  count_sched #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .len     (len),
    .abort   (abort),
    .grant   (grant),
    .busy    (busy),
    .count   (count),
    .done    (done),
    .aborted (aborted)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] grant;
    logic       busy;
    logic [3:0] count;
    logic [3:0] done;
    logic       aborted;
  } snap_t;

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic       abort;
  } stim_t;

  snap_t exp_q[$];
  stim_t stim_q[$];
  int checks = 0;
  int errors = 0;

  function automatic snap_t mk(input logic [3:0] g, input logic b, input int c,
                               input logic [3:0] d, input logic a);
    snap_t s;
    s.grant = g; s.busy = b; s.count = 4'(c); s.done = d; s.aborted = a;
    return s;
  endfunction

  function automatic stim_t st(input logic r, input logic [3:0] q, input logic a);
    stim_t s;
    s.rst = r; s.req = q; s.abort = a;
    return s;
  endfunction

  function automatic snap_t observed();
    snap_t s;
    s.grant = grant; s.busy = busy; s.count = count; s.done = done; s.aborted = aborted;
    return s;
  endfunction

  // Expected outputs after the next edge, and the stimulus applied once seen.
  function automatic void push(input stim_t s, input snap_t e);
    exp_q.push_back(e);
    stim_q.push_back(s);
  endfunction

  task automatic apply(input stim_t s);
    reset = s.rst; req = s.req; abort = s.abort;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; req = '0; abort = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  snap_t Z;

  task automatic test_reset();
    int step = 0;
    apply(st(1'b1, 4'b1111, 1'b0));
    push(st(1'b1, 4'b1111, 1'b0), Z);
    push(st(1'b1, 4'b1111, 1'b0), Z);
    push(st(1'b0, 4'b0000, 1'b0), Z);
    push(st(1'b0, 4'b0000, 1'b0), Z);
    while (exp_q.size() > 0) begin
      snap_t e, o;
      stim_t s;
      e = exp_q.pop_front(); s = stim_q.pop_front();
      @(negedge clock);
      o = observed();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset step %0d: got %b required %b (grant|busy|count|done|aborted)", step, o, e);
      end
      apply(s); step++;
    end
  endtask

  task automatic test_single();
    int step = 0;
    do_reset();
    len = 16'h0003;
    apply(st(1'b0, 4'b0001, 1'b0));
    for (int c = 0; c < 3; c++) push(st(1'b0, 4'b0001, 1'b0), mk(4'b0001, 1'b1, c, 4'b0000, 1'b0));
    push(st(1'b0, 4'b0000, 1'b0), mk(4'b0000, 1'b0, 0, 4'b0001, 1'b0));
    push(st(1'b0, 4'b0000, 1'b0), Z);
    push(st(1'b0, 4'b0000, 1'b0), Z);
    while (exp_q.size() > 0) begin
      snap_t e, o;
      stim_t s;
      e = exp_q.pop_front(); s = stim_q.pop_front();
      @(negedge clock);
      o = observed();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL single step %0d: got %b required %b (grant|busy|count|done|aborted)", step, o, e);
      end
      apply(s); step++;
    end
  endtask

  task automatic test_round_robin();
    int step = 0;
    logic [3:0] oh;
    do_reset();
    len = 16'h2222;
    apply(st(1'b0, 4'b1111, 1'b0));
    for (int g = 0; g < 5; g++) begin
      oh = 4'(1 << (g % 4));
      push(st(1'b0, 4'b1111, 1'b0), mk(oh, 1'b1, 0, 4'b0000, 1'b0));
      push(st(1'b0, 4'b1111, 1'b0), mk(oh, 1'b1, 1, 4'b0000, 1'b0));
      push(st(1'b0, 4'b1111, 1'b0), mk(4'b0000, 1'b0, 0, oh, 1'b0));
      push((g == 4) ? st(1'b0, 4'b0000, 1'b0) : st(1'b0, 4'b1111, 1'b0), Z);
    end
    push(st(1'b0, 4'b0000, 1'b0), Z);
    while (exp_q.size() > 0) begin
      snap_t e, o;
      stim_t s;
      e = exp_q.pop_front(); s = stim_q.pop_front();
      @(negedge clock);
      o = observed();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL round_robin step %0d: got %b required %b (grant|busy|count|done|aborted)", step, o, e);
      end
      apply(s); step++;
    end
  endtask

  task automatic test_wrap();
    int step = 0;
    do_reset();
    len = 16'h0000;
    apply(st(1'b0, 4'b0010, 1'b0));
    for (int c = 0; c < 16; c++) push(st(1'b0, 4'b0010, 1'b0), mk(4'b0010, 1'b1, c, 4'b0000, 1'b0));
    push(st(1'b0, 4'b0000, 1'b0), mk(4'b0000, 1'b0, 0, 4'b0010, 1'b0));
    push(st(1'b0, 4'b0000, 1'b0), Z);
    while (exp_q.size() > 0) begin
      snap_t e, o;
      stim_t s;
      e = exp_q.pop_front(); s = stim_q.pop_front();
      @(negedge clock);
      o = observed();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL wrap step %0d: got %b required %b (grant|busy|count|done|aborted)", step, o, e);
      end
      apply(s); step++;
    end
  endtask

  task automatic test_abort();
    int step = 0;
    // Abort at count 3, then confirm the pointer moved on to requester 1.
    do_reset();
    len = 16'h0058;
    apply(st(1'b0, 4'b0001, 1'b0));
    for (int c = 0; c < 3; c++) push(st(1'b0, 4'b0001, 1'b0), mk(4'b0001, 1'b1, c, 4'b0000, 1'b0));
    push(st(1'b0, 4'b0001, 1'b1), mk(4'b0001, 1'b1, 3, 4'b0000, 1'b0));
    push(st(1'b0, 4'b0000, 1'b0), mk(4'b0000, 1'b0, 0, 4'b0001, 1'b1));
    push(st(1'b0, 4'b0011, 1'b0), Z);
    push(st(1'b0, 4'b0011, 1'b1), mk(4'b0010, 1'b1, 0, 4'b0000, 1'b0));
    push(st(1'b0, 4'b0000, 1'b0), mk(4'b0000, 1'b0, 0, 4'b0010, 1'b1));
    push(st(1'b0, 4'b0000, 1'b0), Z);
    while (exp_q.size() > 0) begin
      snap_t e, o;
      stim_t s;
      e = exp_q.pop_front(); s = stim_q.pop_front();
      @(negedge clock);
      o = observed();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL abort step %0d: got %b required %b (grant|busy|count|done|aborted)", step, o, e);
      end
      apply(s); step++;
    end
    // Requester 0 drops its request at count 5.
    step = 0;
    do_reset();
    apply(st(1'b0, 4'b0001, 1'b0));
    for (int c = 0; c < 5; c++) push(st(1'b0, 4'b0001, 1'b0), mk(4'b0001, 1'b1, c, 4'b0000, 1'b0));
    push(st(1'b0, 4'b0000, 1'b0), mk(4'b0001, 1'b1, 5, 4'b0000, 1'b0));
    push(st(1'b0, 4'b0000, 1'b0), mk(4'b0000, 1'b0, 0, 4'b0001, 1'b1));
    push(st(1'b0, 4'b0000, 1'b0), Z);
    while (exp_q.size() > 0) begin
      snap_t e, o;
      stim_t s;
      e = exp_q.pop_front(); s = stim_q.pop_front();
      @(negedge clock);
      o = observed();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL req_drop step %0d: got %b required %b (grant|busy|count|done|aborted)", step, o, e);
      end
      apply(s); step++;
    end
  endtask

  task automatic test_abort_at_terminal();
    int step = 0;
    do_reset();
    len = 16'h0004;
    apply(st(1'b0, 4'b0001, 1'b0));
    for (int c = 0; c < 3; c++) push(st(1'b0, 4'b0001, 1'b0), mk(4'b0001, 1'b1, c, 4'b0000, 1'b0));
    push(st(1'b0, 4'b0001, 1'b1), mk(4'b0001, 1'b1, 3, 4'b0000, 1'b0));
    push(st(1'b0, 4'b0000, 1'b0), mk(4'b0000, 1'b0, 0, 4'b0001, 1'b0));
    push(st(1'b0, 4'b0000, 1'b0), Z);
    while (exp_q.size() > 0) begin
      snap_t e, o;
      stim_t s;
      e = exp_q.pop_front(); s = stim_q.pop_front();
      @(negedge clock);
      o = observed();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL abort_terminal step %0d: got %b required %b (grant|busy|count|done|aborted)", step, o, e);
      end
      apply(s); step++;
    end
  endtask

  task automatic test_reset_mid();
    int step = 0;
    do_reset();
    len = 16'h0306;
    apply(st(1'b0, 4'b0001, 1'b0));
    for (int c = 0; c < 2; c++) push(st(1'b0, 4'b0001, 1'b0), mk(4'b0001, 1'b1, c, 4'b0000, 1'b0));
    push(st(1'b1, 4'b0100, 1'b0), mk(4'b0001, 1'b1, 2, 4'b0000, 1'b0));
    push(st(1'b0, 4'b0100, 1'b0), Z);
    push(st(1'b0, 4'b0100, 1'b1), mk(4'b0100, 1'b1, 0, 4'b0000, 1'b0));
    push(st(1'b0, 4'b0000, 1'b0), mk(4'b0000, 1'b0, 0, 4'b0100, 1'b1));
    push(st(1'b0, 4'b0000, 1'b0), Z);
    while (exp_q.size() > 0) begin
      snap_t e, o;
      stim_t s;
      e = exp_q.pop_front(); s = stim_q.pop_front();
      @(negedge clock);
      o = observed();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid step %0d: got %b required %b (grant|busy|count|done|aborted)", step, o, e);
      end
      apply(s); step++;
    end
  endtask

  initial begin
    Z = mk(4'b0000, 1'b0, 0, 4'b0000, 1'b0);
    reset = 1'b1;
    req   = '0;
    abort = 1'b0;
    len   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_abort();
    test_abort_at_terminal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
